// File: rtl/loader_pkg.sv
// Shared encodings and constants for the UART program loader.
package loader_pkg;

    // Number of little-endian header bytes that carry the payload length.
    localparam int unsigned LEN_BYTES  = 4;
    // Downstream instruction word size; the payload is padded up to a multiple of this.
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        L_LEN,
        L_DATA,
        L_PAD,
        L_DONE
    } ld_state_t;

    // Zero bytes needed to finish the last word, given length[1:0] (only called when non-zero).
    function automatic logic [2:0] pad_bytes(input logic [1:0] len_lo);
        return 3'(WORD_BYTES) - {1'b0, len_lo};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid strobe.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HalfBit = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT / 2 : 1;

    rx_state_t       state_q;
    logic            rx_meta_q;
    logic            rx_sync_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            frame_err_q;

    // Synchronizer plus receive FSM; valid pulses the cycle after a good stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= R_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            valid_q   <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_sync_q) state_q <= R_START;
                end
                R_START: begin
                    if (cnt_q == CntW'(HalfBit - 1)) begin
                        cnt_q   <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_q <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= R_STOP;
                        else               bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= R_IDLE;
                        if (rx_sync_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: length header, payload bytes, zero padding to a whole word.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [DEPTH-1:0] byte_out,
    output logic             byte_we,
    output logic             loading,
    output logic             load_done,
    output logic             cpu_rst,
    output logic             frame_err
);

    logic [7:0] rx_data;
    logic       rx_valid;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(frame_err)
    );

    ld_state_t        state_q;
    logic [31:0]      remain_q;   // header shift register in L_LEN, bytes left in L_DATA
    logic [1:0]       len_lo_q;
    logic [1:0]       hdr_cnt_q;
    logic [2:0]       pad_cnt_q;
    logic [DEPTH-1:0] hold_q;
    logic [31:0]      len_full;
    logic             data_we;
    logic             pad_we;

    assign len_full = {rx_data, remain_q[31:8]};
    assign data_we  = (state_q == L_DATA) && rx_valid;
    assign pad_we   = (state_q == L_PAD);

    // Write strobe and byte follow rx_valid in the same cycle; byte_out holds otherwise.
    always_comb begin
        byte_we  = data_we || pad_we;
        byte_out = hold_q;
        if (data_we)     byte_out = DEPTH'(rx_data);
        else if (pad_we) byte_out = '0;
        loading   = ((state_q == L_LEN) && ((hdr_cnt_q != 2'd0) || rx_valid)) ||
                    (state_q == L_DATA) || (state_q == L_PAD);
        load_done = (state_q == L_DONE);
        cpu_rst   = rst || !load_done;
    end

    // Loader FSM: collect length, forward payload, pad, then ignore the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= L_LEN;
            remain_q  <= '0;
            len_lo_q  <= '0;
            hdr_cnt_q <= '0;
            pad_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            hold_q <= byte_out;
            case (state_q)
                L_LEN: begin
                    if (rx_valid) begin
                        remain_q  <= len_full;
                        hdr_cnt_q <= hdr_cnt_q + 1'b1;
                        if (hdr_cnt_q == 2'(LEN_BYTES - 1)) begin
                            len_lo_q <= len_full[1:0];
                            state_q  <= (len_full == 32'd0) ? L_DONE : L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (rx_valid && (remain_q != 32'd0)) begin
                        remain_q <= remain_q - 32'd1;
                        if (remain_q == 32'd1) begin
                            if (len_lo_q == 2'd0) begin
                                state_q <= L_DONE;
                            end else begin
                                pad_cnt_q <= pad_bytes(len_lo_q);
                                state_q   <= L_PAD;
                            end
                        end
                    end
                end
                L_PAD: begin
                    pad_cnt_q <= pad_cnt_q - 3'd1;
                    if (pad_cnt_q == 3'd1) state_q <= L_DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the byte width of byte_out.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port rx  input  1  asynchronous UART serial line; idles high; 8N1 framing, LSB first.
REQ-006 The block SHALL have port byte_out  output  DEPTH  program byte presented to the instruction text memory.
REQ-007 The block SHALL have port byte_we  output  1  one-cycle write strobe qualifying byte_out.
REQ-008 The block SHALL have port loading  output  1  high from the first length byte until the load completes.
REQ-009 The block SHALL have port load_done  output  1  high once every payload and pad byte has been written; sticky until rst.
REQ-010 The block SHALL have port cpu_rst  output  1  core hold-reset; equals rst OR NOT load_done.
REQ-011 The block SHALL have port frame_err  output  1  sticky flag: a stop bit was sampled low.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
- R_IDLE -> R_START on synchronized rx = 0.
- R_START: wait CLKS_PER_BIT/2 cycles, re-sample; low -> R_DATA, high -> R_IDLE (glitch rejected).
- R_DATA: sample 8 bits, each CLKS_PER_BIT cycles apart at mid-bit, LSB first.
- R_STOP: sample at mid-bit; high -> byte valid; low -> discard the byte and set frame_err. Either way -> R_IDLE.
REQ-014 A valid RX byte SHALL raise an internal rx_valid for exactly 1 cycle, on the cycle after the stop-bit sample.
REQ-015 Loader FSM states SHALL be L_LEN, L_DATA, L_PAD, L_DONE.
REQ-016 L_LEN: the first 4 valid bytes SHALL form a 32-bit payload length, little-endian; loading rises on the first of these bytes.
REQ-017 After the 4th length byte, the loader SHALL go to L_DATA if length != 0; if length == 0 it SHALL go directly to L_DONE, with no byte_we pulses.
REQ-018 L_DATA: each rx_valid SHALL drive byte_out = rx byte and byte_we = 1 in the same cycle, and decrement the remaining count.
REQ-019 When the remaining count reaches 0: if length mod 4 == 0 the loader SHALL go to L_DONE; otherwise it SHALL go to L_PAD.
REQ-020 L_PAD SHALL emit (4 - length mod 4) bytes of 0x00, one per cycle on consecutive cycles, each with byte_we = 1, then go to L_DONE. This guarantees that the downstream word assembly completes its last word.
REQ-021 L_DONE: load_done = 1 and loading = 0; further RX bytes SHALL be ignored (no byte_we).
REQ-022 byte_we SHALL never be high for more than one cycle per byte; byte_out SHALL hold its last value while byte_we = 0.
REQ-023 The remaining-count arithmetic SHALL be 32-bit unsigned; the count SHALL never underflow.
REQ-024 frame_err SHALL have no effect on loader state: a discarded byte is simply not counted.

Reset
REQ-025 On rst = 1, at the next clk edge:
- both FSMs SHALL return to R_IDLE / L_LEN;
- length, remaining count and bit/baud counters SHALL clear;
- byte_out = 0, byte_we = 0, loading = 0, load_done = 0, frame_err = 0;
- synchronizer flops = 1.
REQ-026 rst asserted mid-frame or mid-load SHALL abort immediately; a new load SHALL start fresh with the length header.
REQ-027 cpu_rst SHALL be 1 throughout rst and every load.

Structure
REQ-028 A shared package loader_pkg SHALL hold the RX and loader state encodings, LEN_BYTES = 4, and WORD_BYTES = 4.
REQ-029 UART deserialization SHALL be a sub-module uart_rx (ports clk, rst, rx, data, valid, frame_err); prog_loader SHALL instantiate it once and contain the loader FSM.

Verification (CLKS_PER_BIT = 4)
REQ-030 Length = 8 followed by bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 -> exactly 8 byte_we pulses carrying those values in order; load_done = 1 and cpu_rst = 0 afterwards.
REQ-031 Length = 5 with payload 0xAA..0xAE -> 5 data pulses, then 3 consecutive pulses of 0x00; load_done = 1.
REQ-032 Length = 0 -> no byte_we pulses; load_done = 1 right after the 4th header byte.
REQ-033 A 1-cycle low glitch on rx while idle -> no byte received, state unchanged; a frame with its stop bit low -> frame_err = 1 and that byte is not counted.
REQ-034 rst pulsed after 2 of 8 payload bytes -> all outputs 0; then a full new load of length 4 -> 4 pulses, load_done = 1.
REQ-035 A byte sent after load_done -> no byte_we pulse; load_done stays 1.
